// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, op encoding, mstatus layout, WARL masks and FSM states.
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    typedef enum logic [1:0] {OP_READ = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam logic [63:0] MSTATUS_RST   = 64'h1800;
    localparam logic [63:0] MSTATUS_WMASK = 64'h88;
    localparam logic [63:0] MTVEC_WMASK   = ~64'h2;
    localparam logic [63:0] MEPC_WMASK    = ~64'h3;
    localparam logic [63:0] MCAUSE_WMASK  = ~64'h0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/csr_cycle_counter.sv
// csr_cycle_counter: free-running 64-bit mcycle; a write to either half replaces it and skips that increment.
module csr_cycle_counter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_lo_i,
    input  logic            wr_hi_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [63:0]     cnt_o
);
    logic [63:0] cnt_q, cnt_d, wide;

    assign wide = 64'(wdata_i);
    assign cnt_o = cnt_q;

    always_comb
        cnt_d = !(wr_lo_i || wr_hi_i) ? cnt_q + 64'd1 :
                XLEN == 64 ? wide :
                {wr_hi_i ? wide[31:0] : cnt_q[63:32], wr_lo_i ? wide[31:0] : cnt_q[31:0]};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with a latency-configurable request/response channel,
// atomic trap/mret ports, WARL masking and mcycle.
module csr_unit
    import csr_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          WR_LAT     = 1,
    parameter logic [31:0] MISA_VAL   = 32'h40001100,
    parameter bit          HAS_MCYCLE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mstatus_o,
    output logic [XLEN-1:0] mcause_o
);
    localparam int CW = $clog2(WR_LAT + 1);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rdata_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic            err_q, mie_q, mpie_q;
    logic [XLEN-1:0] mstatus, old, new_val, base;
    logic [63:0]     cyc;
    logic            legal, ro, wr_req, acc, wr, wr_lo, wr_hi;

    assign mstatus = XLEN'(MSTATUS_RST) | (XLEN'(mpie_q) << MSTATUS_MPIE) | (XLEN'(mie_q) << MSTATUS_MIE);

    always_comb begin
        old   = '0;
        legal = 1'b1;
        case (req_addr)
            CSR_MSTATUS:               old = mstatus;
            CSR_MISA:                  old = XLEN'(MISA_VAL);
            CSR_MTVEC:                 old = mtvec_q;
            CSR_MSCRATCH:              old = mscratch_q;
            CSR_MEPC:                  old = mepc_q;
            CSR_MCAUSE:                old = mcause_q;
            CSR_MCYCLE:                begin old = cyc[XLEN-1:0]; legal = HAS_MCYCLE; end
            CSR_MCYCLEH:               begin old = XLEN'(cyc[63:32]); legal = HAS_MCYCLE && XLEN == 32; end
            CSR_MVENDORID, CSR_MARCHID: old = '0;
            default:                   legal = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it never trips the read-only check
    assign ro      = req_addr[11:10] == 2'b11 || req_addr == CSR_MISA;
    assign wr_req  = req_op == OP_RW || (req_op != OP_READ && req_wdata != '0);
    assign new_val = req_op == OP_RW ? req_wdata : req_op == OP_RS ? old | req_wdata : old & ~req_wdata;
    assign acc     = req_valid && req_ready;
    assign wr      = acc && legal && !ro && wr_req;
    assign wr_lo   = wr && req_addr == CSR_MCYCLE;
    assign wr_hi   = wr && req_addr == CSR_MCYCLEH;

    assign req_ready = state_q == IDLE && !trap_valid && !mret_valid;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign base        = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_vector = mtvec_q[0] && trap_cause[XLEN-1] ? base + XLEN'({trap_cause[XLEN-2:0], 2'b00}) : base;

    assign mepc_o    = mepc_q;
    assign mtvec_o   = mtvec_q;
    assign mstatus_o = mstatus;
    assign mcause_o  = mcause_q;

    generate
        if (HAS_MCYCLE) begin : g_cyc
            csr_cycle_counter #(.XLEN(XLEN)) u_cyc (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_lo_i (wr_lo),
                .wr_hi_i (wr_hi),
                .wdata_i (new_val),
                .cnt_o   (cyc)
            );
        end else begin : g_nocyc
            assign cyc = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (trap_valid) begin
            mepc_q   <= trap_pc & XLEN'(MEPC_WMASK);
            mcause_q <= trap_cause;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret_valid) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr) begin
            case (req_addr)
                CSR_MSTATUS: begin
                    mie_q  <= new_val[MSTATUS_MIE];
                    mpie_q <= new_val[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_q    <= new_val & XLEN'(MTVEC_WMASK);
                CSR_MSCRATCH: mscratch_q <= new_val;
                CSR_MEPC:     mepc_q     <= new_val & XLEN'(MEPC_WMASK);
                CSR_MCAUSE:   mcause_q   <= new_val & XLEN'(MCAUSE_WMASK);
                default:      ;
            endcase
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (acc) begin
                    rdata_q <= legal ? old : '0;
                    err_q   <= !legal || (ro && wr_req);
                    cnt_q   <= CW'(WR_LAT > 1 ? WR_LAT - 2 : 0);
                    state_q <= WR_LAT > 1 ? WAIT : RESP;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= RESP;
                end
                RESP: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed and randomized checks of csr_unit (XLEN=32, WR_LAT=3) against a behavioural model.
module tb_csr_unit;
    localparam int LAT = 3;

    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err;
    logic [1:0]  req_op = 0;
    logic [11:0] req_addr = 0;
    logic [31:0] req_wdata = 0, rsp_rdata, trap_cause = 0, trap_pc = 0, trap_vector;
    logic        trap_valid = 0, mret_valid = 0;
    logic [31:0] mepc_o, mtvec_o, mstatus_o, mcause_o;

    csr_unit #(.XLEN(32), .WR_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .mret_valid(mret_valid),
        .trap_vector(trap_vector), .mepc_o(mepc_o), .mtvec_o(mtvec_o), .mstatus_o(mstatus_o), .mcause_o(mcause_o)
    );

    always #5 clk = ~clk;

    int unsigned edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int total = 0, bad = 0;

    // Reference model: architectural CSR state, mcycle as a base value plus elapsed edges
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] cyc_base;
    int unsigned cyc_edge;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_mstatus();
        return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [63:0] cyc_at(input int unsigned e);
        return cyc_base + 64'(e - 1 - cyc_edge);
    endfunction

    function automatic void m_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        cyc_base = 0; cyc_edge = edges;
    endfunction

    function automatic void m_trap(input logic [31:0] c, input logic [31:0] pc);
        m_mepc = pc & ~32'h3;
        m_mcause = c;
        m_mpie = m_mie;
        m_mie = 0;
    endfunction

    function automatic void model(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                                  input int unsigned a, output logic [31:0] rd, output logic er);
        logic [31:0] old, nv;
        logic [63:0] v;
        bit legal, ro, writes;
        legal = 1; old = 0; v = cyc_at(a);
        case (addr)
            12'h300: old = m_mstatus();
            12'h301: old = 32'h40001100;
            12'h305: old = m_mtvec;
            12'h340: old = m_mscratch;
            12'h341: old = m_mepc;
            12'h342: old = m_mcause;
            12'hB00: old = v[31:0];
            12'hB80: old = v[63:32];
            12'hF11, 12'hF12: old = 0;
            default: legal = 0;
        endcase
        ro = addr >= 12'hC00 || addr == 12'h301;
        writes = op == 2'b01 || (op != 2'b00 && wd != 0);
        rd = legal ? old : 32'h0;
        er = !legal || (ro && writes);
        if (!er && writes) begin
            nv = op == 2'b01 ? wd : op == 2'b10 ? (old | wd) : (old & ~wd);
            case (addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h305: m_mtvec = nv & ~32'h2;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'hB00: begin cyc_base = {v[63:32], nv}; cyc_edge = a; end
                12'hB80: begin cyc_base = {nv, v[31:0]}; cyc_edge = a; end
                default: ;
            endcase
        end
    endfunction

    task automatic check_outs();
        check("mstatus_o", mstatus_o, m_mstatus());
        check("mtvec_o", mtvec_o, m_mtvec);
        check("mepc_o", mepc_o, m_mepc);
        check("mcause_o", mcause_o, m_mcause);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                          input int hold, input bit tw, output logic [31:0] rd, output logic er);
        int n;
        int unsigned a;
        logic [31:0] erd;
        logic eer;
        @(negedge clk);
        req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("req_ready", req_ready, 1);
        @(posedge clk); #1;
        a = edges; req_valid = 0;
        model(op, addr, wd, a, erd, eer);
        if (tw) begin trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = $urandom; end
        n = 1;
        while (!rsp_valid && n < LAT + 10) begin
            @(posedge clk); #1;
            if (tw && n == 1) begin trap_valid = 0; m_trap(trap_cause, trap_pc); end
            n++;
        end
        check("latency", n, LAT);
        check("rsp_rdata", rsp_rdata, erd);
        check("rsp_err", rsp_err, eer);
        rd = rsp_rdata; er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, erd);
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        check("rsp_drop", rsp_valid, 0);
        check_outs();
    endtask

    task automatic do_trap(input logic [31:0] c, input logic [31:0] pc, input bit both);
        logic [31:0] b, ev;
        @(negedge clk);
        trap_valid = 1; trap_cause = c; trap_pc = pc; mret_valid = both;
        req_valid = 1; req_op = 2'b01; req_addr = 12'h340; req_wdata = $urandom;
        b = m_mtvec & ~32'h3;
        ev = (m_mtvec[0] && c[31]) ? b + {1'b0, c[30:0]} * 4 : b;
        #1;
        check("trap_req_ready", req_ready, 0);
        check("trap_vector", trap_vector, ev);
        @(posedge clk); #1;
        trap_valid = 0; mret_valid = 0; req_valid = 0;
        m_trap(c, pc);
        check("trap_no_rsp", rsp_valid, 0);
        check_outs();
    endtask

    task automatic do_mret();
        @(negedge clk);
        mret_valid = 1;
        #1;
        check("mret_req_ready", req_ready, 0);
        @(posedge clk); #1;
        mret_valid = 0;
        m_mie = m_mpie; m_mpie = 1;
        check_outs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic er;
        logic [11:0] alist [12];
        logic [11:0] ad;
        logic [31:0] wd;
        int r;
        alist = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                  12'hB00, 12'hB80, 12'hF11, 12'hF12, 12'hC00, 12'h7C0};

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_mstatus", mstatus_o, 32'h1800);
        check("rst_mtvec", mtvec_o, 0);
        check("rst_mepc", mepc_o, 0);
        rst_n = 1;
        m_reset();

        do_req(2'b01, 12'h305, 32'h8000_0003, 0, 0, rd, er);
        check("mtvec_old", rd, 0);
        check("mtvec_warl", mtvec_o, 32'h8000_0001);
        do_req(2'b00, 12'h305, 0, 0, 0, rd, er);
        check("mtvec_read", rd, 32'h8000_0001);

        do_req(2'b10, 12'h300, 32'h8, 0, 0, rd, er);
        check("rs_old", rd, 32'h1800);
        do_req(2'b11, 12'h300, 32'h8, 0, 0, rd, er);
        check("rc_old", rd, 32'h1808);
        do_req(2'b00, 12'h300, 0, 0, 0, rd, er);
        check("mstatus_read", rd, 32'h1800);

        do_req(2'b01, 12'hF11, 32'h55, 0, 0, rd, er);
        check("ro_err", er, 1);
        do_req(2'b10, 12'hF11, 0, 0, 0, rd, er);
        check("ro_rs0_err", er, 0);
        check("ro_rs0_rd", rd, 0);
        do_req(2'b01, 12'h7C0, 32'h1, 0, 0, rd, er);
        check("illegal_err", er, 1);
        check("illegal_rd", rd, 0);

        do_req(2'b10, 12'h300, 32'h8, 0, 0, rd, er);
        do_trap(32'hB, 32'h8000_0102, 0);
        check("trap_mepc", mepc_o, 32'h8000_0100);
        check("trap_mcause", mcause_o, 32'hB);
        check("trap_mstatus", mstatus_o, 32'h1880);
        do_mret();
        check("mret_mstatus", mstatus_o, 32'h1888);

        do_req(2'b01, 12'h340, 32'hDEAD_BEEF, 0, 0, rd, er);
        do_req(2'b00, 12'h340, 0, 5, 0, rd, er);
        check("held_read", rd, 32'hDEAD_BEEF);

        do_req(2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 0, rd, er);
        do_req(2'b00, 12'hB80, 0, 0, 0, rd, er);
        check("mcycleh_carry", rd, 1);
        do_req(2'b00, 12'hB00, 0, 0, 0, rd, er);

        do_req(2'b00, 12'h341, 0, 2, 1, rd, er);

        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 99);
            if (r < 10) do_trap($urandom, $urandom, 0);
            else if (r < 16) do_mret();
            else if (r < 20) do_trap($urandom, $urandom, 1);
            else begin
                ad = $urandom_range(0, 12) == 12 ? 12'($urandom) : alist[$urandom_range(0, 11)];
                wd = $urandom_range(0, 3) == 0 ? 32'h0 : $urandom;
                do_req(2'($urandom), ad, wd, $urandom_range(0, 2), 0, rd, er);
            end
        end

        @(negedge clk);
        req_valid = 1; req_op = 2'b01; req_addr = 12'h340; req_wdata = 32'h1234;
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_rdata", rsp_rdata, 0);
        check("arst_mstatus", mstatus_o, 32'h1800);
        check("arst_mtvec", mtvec_o, 0);
        check("arst_mcause", mcause_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        m_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("arst_no_rsp", rsp_valid, 0);
        end
        do_req(2'b00, 12'h340, 0, 0, 0, rd, er);
        check("arst_mscratch", rd, 0);
        do_req(2'b00, 12'hB00, 0, 0, 0, rd, er);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Second-generation machine-mode CSR file for the NPC core; replaces the fixed four-write-port CSR block.
- Serves one CSR-instruction channel (csrrw/csrrs/csrrc) through a valid/ready request and a valid/ready response with configurable latency.
- Provides dedicated atomic trap-entry and mret ports, applies WARL masking, and runs a free-running 64-bit mcycle counter.
- Sits beside the regfile, between the decode/EXU and the WBU.

Parameters:
- XLEN, 32, CSR data width; legal values are 32 and 64.
- WR_LAT, 1, cycles from request acceptance to rsp_valid; WR_LAT >= 1.
- MISA_VAL, 32'h40001100, read-only value of misa (RV32IM).
- HAS_MCYCLE, 1, implements mcycle/mcycleh; when 0, those addresses are illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CSR instruction request
- req_ready  out  1  unit can accept a request this cycle
- req_op  in  2  00 read, 01 RW, 10 RS, 11 RC
- req_addr  in  12  CSR address
- req_wdata  in  XLEN  rs1 or uimm operand; 0 when rs1 is x0
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  XLEN  CSR value before the write
- rsp_err  out  1  illegal access; no state was changed
- trap_valid  in  1  single-cycle trap-entry pulse
- trap_cause  in  XLEN  mcause value
- trap_pc  in  XLEN  faulting PC
- mret_valid  in  1  single-cycle mret pulse
- trap_vector  out  XLEN  combinational next PC on a trap
- mepc_o, mtvec_o, mstatus_o, mcause_o  out  XLEN each  live register values for difftest

Behaviour:
- Address map:
  - mstatus 0x300, misa 0x301 (RO), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
  - mcycle 0xB00; mcycleh 0xB80 (only when XLEN=32).
  - mvendorid 0xF11 = 0, marchid 0xF12 = 0.
  - Every other address is illegal.
- Reset (rst_n low, asynchronous), taking effect immediately:
  - mstatus = 0x1800 (MPP=11); all other writable registers and mcycle = 0.
  - FSM returns to IDLE, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - A pending response is dropped.
- FSM states and transitions:
  - IDLE: req_ready = !trap_valid && !mret_valid. On accept, go to WAIT if WR_LAT > 1, else RESP.
  - WAIT: down-counter of WR_LAT-1 cycles, then RESP.
  - RESP: rsp_valid = 1; rsp_rdata and rsp_err hold stable until rsp_ready; then return to IDLE.
  - Result: rsp_valid first rises exactly WR_LAT cycles after the accept edge.
  - No new request is accepted until the cycle after the response handshake.
- Accept edge:
  - rsp_rdata captures the old value; the write commits on the same edge.
  - New value by op: RW = wdata, RS = old | wdata, RC = old & ~wdata, read = no write.
  - RS/RC with wdata == 0 perform no write and raise no RO error.
- Errors:
  - Illegal address: rsp_err = 1, rsp_rdata = 0, no write.
  - Writing a read-only register (addr[11:10] == 11, or misa): rsp_err = 1, rsp_rdata = old value, no write.
- WARL rules:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] always reads 11; all other bits read 0.
  - mtvec: MODE[1] is forced to 0.
  - mepc: bits[1:0] are forced to 0.
  - mcause: fully writable.
- mcycle:
  - Increments by 1 every cycle.
  - A CSR write to mcycle or mcycleh replaces that half on that edge and suppresses the increment for that cycle.
  - Carry from the low half into mcycleh is required for XLEN=32.
- Trap entry (trap_valid):
  - mepc = trap_pc & ~3; mcause = trap_cause.
  - MPIE = MIE; MIE = 0; MPP = 11.
  - Trap entry has priority over mret when both pulse in the same cycle.
- mret (mret_valid): MIE = MPIE; MPIE = 1; MPP = 11.
- trap_vector:
  - MODE = 0: mtvec base.
  - MODE = 1 and trap_cause[XLEN-1] = 1: base + 4 * trap_cause[XLEN-2:0].
  - Otherwise: base.
- Trap/mret and requests never commit in the same cycle, because req_ready is gated by trap_valid and mret_valid. A trap during WAIT or RESP does not disturb the captured response.

Decomposition:
- csr_pkg contains:
  - CSR address localparams and the req_op encoding.
  - mstatus bit indices (MIE, MPIE, MPP) and the mstatus reset value.
  - The WARL write-mask constant for each register.
  - FSM state typedef: IDLE, WAIT, RESP.
- Sub-module csr_cycle_counter: 64-bit counter with XLEN-split write enables (lo/hi) and increment suppression. It is instantiated only when HAS_MCYCLE = 1.

Test Plan:
- Reset, then RW 0x305 with 0x80000003 -> rsp_rdata = 0 after WR_LAT cycles, mtvec_o = 0x80000001; a read returns 0x80000001.
- RS 0x300 with 0x8, then RC 0x300 with 0x8 -> mstatus reads 0x1808, then 0x1800; rsp_rdata returns the pre-write values.
- RW 0xF11 -> rsp_err = 1, no change; RS 0xF11 with 0 -> rsp_err = 0, rdata = 0; RW 0x7C0 -> rsp_err = 1, rdata = 0.
- trap_valid with cause 0xB and pc 0x80000102, MIE = 1 -> mepc = 0x80000100, mcause = 0xB, mstatus = 0x1880, req_ready = 0 that cycle; then mret -> mstatus = 0x1888.
- Hold rsp_ready = 0 for 5 cycles with WR_LAT = 3 -> rsp_valid held, rdata stable, req_ready = 0; rst_n pulsed while in WAIT -> rsp_valid never asserts, registers return to reset values.
- Write mcycle = 0xFFFFFFFF (XLEN = 32) -> next cycle mcycle = 0, mcycleh = 1; the write cycle shows no extra increment.
